// File: rtl/bullet_pkg.sv
// Shared types and constants for the bullet pool and its per-slot engine.
package bullet_pkg;

  typedef logic signed [9:0] vel_t;

  localparam int unsigned WALL_LEFT   = 0;
  localparam int unsigned WALL_RIGHT  = 1;
  localparam int unsigned WALL_TOP    = 2;
  localparam int unsigned WALL_BOTTOM = 3;

  localparam logic [7:0] DEFAULT_STEP = 8'h10;

  // Scale a sign-magnitude Q1.7 heading by the sign-magnitude speed step.
  // flip inverts the resulting direction (screen y grows downward).
  function automatic vel_t heading_vel(input logic [7:0] step,
                                       input logic [7:0] trig,
                                       input logic       flip);
    logic [13:0] prod;
    vel_t        mag;
    prod = {7'b0, step[6:0]} * {7'b0, trig[6:0]};
    mag  = vel_t'({3'b000, prod[13:7]});
    return (step[7] ^ trig[7] ^ flip) ? -mag : mag;
  endfunction

endpackage

// File: rtl/bullet_slot.sv
// One bullet slot: position, velocity, lifetime timer and bounce count.
module bullet_slot
  import bullet_pkg::*;
#(
  parameter int unsigned LIFETIME    = 1000,
  parameter int unsigned MAX_BOUNCES = 0
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic       clear,
  input  logic       spawn,
  input  logic [9:0] spawn_x,
  input  logic [9:0] spawn_y,
  input  vel_t       spawn_vx,
  input  vel_t       spawn_vy,
  input  logic [3:0] wall,
  input  logic       hit,
  output logic       active,
  output logic [9:0] pos_x,
  output logic [9:0] pos_y
);

  // The timer only ever holds 0..LIFETIME-1; it is cleared once the slot dies.
  localparam int unsigned   TW           = (LIFETIME > 1) ? $clog2(LIFETIME) : 1;
  localparam logic [TW-1:0] LAST_MOVE    = TW'(LIFETIME - 1);
  localparam logic [7:0]    BOUNCE_LIMIT = 8'(MAX_BOUNCES);

  vel_t          vx;
  vel_t          vy;
  vel_t          next_vx;
  vel_t          next_vy;
  logic [TW-1:0] timer;
  logic [7:0]    bounces;
  logic          vert_hit;
  logic          horiz_hit;
  logic          any_wall;
  logic          bounce_out;
  logic          expire;

  // Reflection and expiry decisions for the current frame.
  always_comb begin
    vert_hit   = wall[WALL_TOP] | wall[WALL_BOTTOM];
    horiz_hit  = wall[WALL_LEFT] | wall[WALL_RIGHT];
    any_wall   = vert_hit | horiz_hit;
    bounce_out = (MAX_BOUNCES != 0) && any_wall && (bounces == BOUNCE_LIMIT);
    next_vx    = horiz_hit ? -vx : vx;
    next_vy    = vert_hit  ? -vy : vy;
    expire     = (timer == LAST_MOVE);
  end

  // Slot state: spawn load, then per-frame hit / bounce / move / expiry.
  always_ff @(posedge frame_clk) begin
    if (Reset || clear) begin
      active  <= 1'b0;
      pos_x   <= '0;
      pos_y   <= '0;
      vx      <= '0;
      vy      <= '0;
      timer   <= '0;
      bounces <= '0;
    end else if (spawn) begin
      active  <= 1'b1;
      pos_x   <= spawn_x;
      pos_y   <= spawn_y;
      vx      <= spawn_vx;
      vy      <= spawn_vy;
      timer   <= '0;
      bounces <= '0;
    end else if (active) begin
      // A kill or an exhausted bounce budget stops the bullet where it is.
      if (hit || bounce_out) begin
        active <= 1'b0;
      end else begin
        vx    <= next_vx;
        vy    <= next_vy;
        pos_x <= pos_x + $unsigned(next_vx);
        pos_y <= pos_y + $unsigned(next_vy);
        timer <= timer + 1'b1;
        if (any_wall && (bounces != 8'hFF)) begin
          bounces <= bounces + 8'd1;
        end
        if (expire) begin
          active <= 1'b0;
        end
      end
    end else begin
      pos_x   <= '0;
      pos_y   <= '0;
      vx      <= '0;
      vy      <= '0;
      timer   <= '0;
      bounces <= '0;
    end
  end

endmodule

// File: rtl/bullet_pool.sv
// Bullet pool: fire-edge detection, cooldown, slot allocation and live count.
module bullet_pool
  import bullet_pkg::*;
#(
  parameter int unsigned NUM_BULLETS  = 5,
  parameter int unsigned LIFETIME     = 1000,
  parameter int unsigned COOLDOWN     = 8,
  parameter int unsigned SPAWN_OFFSET = 5,
  parameter int unsigned MAX_BOUNCES  = 0,
  parameter logic [7:0]  STEP         = DEFAULT_STEP
) (
  input  logic                        frame_clk,
  input  logic                        Reset,
  input  logic [1:0]                  game_end,
  input  logic                        fire,
  input  logic [9:0]                  tankX,
  input  logic [9:0]                  tankY,
  input  logic [7:0]                  sin,
  input  logic [7:0]                  cos,
  input  logic [4*NUM_BULLETS-1:0]    wall_hit,
  input  logic [NUM_BULLETS-1:0]      hit,
  output logic [10*NUM_BULLETS-1:0]   bullet_x,
  output logic [10*NUM_BULLETS-1:0]   bullet_y,
  output logic [NUM_BULLETS-1:0]      active,
  output logic                        fire_ack,
  output logic [3:0]                  live_count
);

  localparam int unsigned   CW      = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
  localparam logic [CW-1:0] CD_LOAD = CW'(COOLDOWN);
  localparam logic [9:0]    OFFSET  = 10'(SPAWN_OFFSET);

  logic                   fire_q;
  logic [CW-1:0]          cooldown;
  logic                   pool_clear;
  logic                   fire_edge;
  logic                   slot_free;
  logic                   accept;
  logic [NUM_BULLETS-1:0] free_onehot;
  logic [NUM_BULLETS-1:0] spawn;
  vel_t                   shot_vx;
  vel_t                   shot_vy;
  logic [9:0]             shot_x;
  logic [9:0]             shot_y;

  // Velocity and spawn point of a shot fired this frame (wraps modulo 1024).
  always_comb begin
    shot_vx = heading_vel(STEP, cos, 1'b0);
    shot_vy = heading_vel(STEP, sin, 1'b1);
    shot_x  = tankX + OFFSET * $unsigned(shot_vx);
    shot_y  = tankY + OFFSET * $unsigned(shot_vy);
  end

  // Pick the lowest-index slot that was inactive at the start of this frame.
  always_comb begin
    free_onehot = '0;
    slot_free   = 1'b0;
    for (int unsigned i = 0; i < NUM_BULLETS; i++) begin
      if (!active[i] && !slot_free) begin
        free_onehot[i] = 1'b1;
        slot_free      = 1'b1;
      end
    end
    pool_clear = (game_end != 2'b00);
    fire_edge  = fire & ~fire_q;
    accept     = fire_edge && !pool_clear && (cooldown == '0) && slot_free;
    spawn      = accept ? free_onehot : '0;
  end

  // Population count of live slots.
  always_comb begin
    live_count = '0;
    for (int unsigned i = 0; i < NUM_BULLETS; i++) begin
      live_count = live_count + 4'(active[i]);
    end
  end

  // Fire edge history, acknowledge pulse and shot cooldown.
  always_ff @(posedge frame_clk) begin
    if (Reset || pool_clear) begin
      fire_q   <= 1'b0;
      fire_ack <= 1'b0;
      cooldown <= '0;
    end else begin
      fire_q   <= fire;
      fire_ack <= accept;
      if (accept) begin
        cooldown <= CD_LOAD;
      end else if (cooldown != '0) begin
        cooldown <= cooldown - 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NUM_BULLETS; g++) begin : g_slot
    bullet_slot #(
      .LIFETIME    (LIFETIME),
      .MAX_BOUNCES (MAX_BOUNCES)
    ) u_slot (
      .frame_clk (frame_clk),
      .Reset     (Reset),
      .clear     (pool_clear),
      .spawn     (spawn[g]),
      .spawn_x   (shot_x),
      .spawn_y   (shot_y),
      .spawn_vx  (shot_vx),
      .spawn_vy  (shot_vy),
      .wall      (wall_hit[4*g +: 4]),
      .hit       (hit[g]),
      .active    (active[g]),
      .pos_x     (bullet_x[10*g +: 10]),
      .pos_y     (bullet_y[10*g +: 10])
    );
  end

endmodule

// File: doc/bullet_pool.md
BULLET_POOL -- requirements
Module: bullet_pool

Interface
REQ-001 SHALL have parameter NUM_BULLETS, default 5, meaning number of independent bullet slots (1..8).
REQ-002 SHALL have parameter LIFETIME, default 1000, meaning number of motion frames before a bullet expires.
REQ-003 SHALL have parameter COOLDOWN, default 8, meaning frames after an accepted shot during which fire edges are dropped.
REQ-004 SHALL have parameter SPAWN_OFFSET, default 5, meaning spawn distance from the tank in velocity multiples.
REQ-005 SHALL have parameter MAX_BOUNCES, default 0, meaning wall bounces allowed before expiry (0 = unlimited).
REQ-006 SHALL have parameter STEP, default 8'h10, meaning sign-magnitude speed scale.
REQ-007 SHALL have port frame_clk, input, 1, meaning the only clock; one update per frame.
REQ-008 SHALL have port Reset, input, 1, meaning synchronous active-high reset.
REQ-009 SHALL have port game_end, input, 2, meaning that any nonzero value clears the pool.
REQ-010 SHALL have port fire, input, 1, meaning level fire request, rising-edge detected.
REQ-011 SHALL have ports tankX and tankY, input, 10 each, meaning the tank centre.
REQ-012 SHALL have ports sin and cos, input, 8 each, meaning sign-magnitude Q1.7 heading, with bit 7 as the sign.
REQ-013 SHALL have port wall_hit, input, 4*NUM_BULLETS, meaning per slot {bottom, top, right, left}.
REQ-014 SHALL have port hit, input, NUM_BULLETS, meaning per-slot kill (tank struck).
REQ-015 SHALL have ports bullet_x and bullet_y, output, 10*NUM_BULLETS each, meaning packed slot positions.
REQ-016 SHALL have port active, output, NUM_BULLETS, meaning the slot-live flags.
REQ-017 SHALL have port fire_ack, output, 1, meaning a one-frame pulse when a shot is allocated.
REQ-018 SHALL have port live_count, output, 4, meaning the number of set active bits.

Function
REQ-019 SHALL register fire as fire_q; a fire edge is fire & ~fire_q.
REQ-020 SHALL, on a fire edge with cooldown==0, game_end==0 and a free slot, allocate the lowest-index inactive slot at that edge, set fire_ack=1 for that frame only, and load cooldown=COOLDOWN.
REQ-021 SHALL drop a fire edge when no slot is free or cooldown!=0; there is no queueing, and fire_ack stays 0.
REQ-022 SHALL judge slot freedom from registered active, so a slot freed this frame is allocatable only from the next frame.
REQ-023 SHALL compute velocity at allocation as mag = (STEP[6:0]*|trig|)[13:7], vx = (STEP[7]^cos[7]) ? -mag : +mag, vy = (STEP[7]^sin[7]) ? +mag : -mag, as 10-bit two's complement (screen y grows down).
REQ-024 SHALL set spawn position = tank + SPAWN_OFFSET*v, modulo 1024, with timer=0 and bounces=0.
REQ-025 SHALL, for each active slot each frame, deactivate with position held if hit=1 (highest priority).
REQ-026 SHALL otherwise negate vy on a top or bottom hit, negate vx on a left or right hit, and negate both when a vertical and a horizontal flag are both set.
REQ-027 SHALL then update pos += new velocity, wrapping modulo 1024.
REQ-028 SHALL increment timer per move and deactivate on the frame where timer==LIFETIME-1, giving exactly LIFETIME moves.
REQ-029 SHALL increment bounces per frame with any wall flag; with MAX_BOUNCES>0, a wall hit while bounces==MAX_BOUNCES deactivates the slot instead of reflecting it.
REQ-030 SHALL decrement cooldown by 1 per frame down to 0.
REQ-031 SHALL ignore wall_hit and hit on inactive slots.
REQ-032 SHALL hold inactive slot positions at 0.
REQ-033 SHALL, while game_end!=0, clear all state as reset does and ignore fire.

Reset
REQ-034 SHALL, on Reset=1 at a frame_clk edge, clear active, fire_ack, live_count, bullet_x, bullet_y, velocities, timers, bounces, cooldown and fire_q to 0.
REQ-035 SHALL let Reset take priority over game_end, fire and all slot events, including mid-flight.

Structure
REQ-036 SHALL place vel_t (signed 10-bit), the wall-bit indices (BOTTOM=3, TOP=2, RIGHT=1, LEFT=0) and the default STEP in a shared package bullet_pkg.
REQ-037 SHALL implement one sub-module, bullet_slot, holding per-slot motion, timer and bounce state, instantiated NUM_BULLETS times by generate; allocation, cooldown and counting stay in bullet_pool.

Verification
REQ-038 SHALL verify spawn and motion: tank=(100,200), cos=8'h7F, sin=8'h00, fire edge -> slot0 active, fire_ack=1 for one frame, pos=(175,200); next frame x=190.
REQ-039 SHALL verify pool full: NUM_BULLETS=2, COOLDOWN=2, three fire edges 4 frames apart -> slots 0 and 1 live, third dropped with fire_ack=0, live_count=2.
REQ-040 SHALL verify a right-wall bounce: slot at x=300 with vx=+15, wall_hit right -> vx=-15, x=285 that frame.
REQ-041 SHALL verify lifetime: LIFETIME=4 -> exactly 4 moves, then active=0 and live_count=0.
REQ-042 SHALL verify event priority: hit and wall on the same frame -> slot inactive and position unchanged; MAX_BOUNCES=1, second wall hit -> slot inactive.
REQ-043 SHALL verify game end: game_end=2'b01 mid-flight -> all active=0 next edge, fire edges ignored until game_end=0.
